pc_gen: RTL and testbench

Program-counter generator for the single-issue RISC-V core. Holds the architectural fetch PC and selects the next PC from four sources: sequential, branch, jump and trap. It presents the PC to instruction fetch over a valid/ready handshake and accepts redirects from the execute stage. It is the stage directly upstream of fetch and directly downstream of the next-PC 4:1 select.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_next_mux.sv | 57 +++++
 rtl/pc_gen.sv | 118 +++++++++++
 tb/tb_pc_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch front end: next-PC source select, PC
// generator FSM states and the fixed instruction size.
package cpu_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic [SEL_W-1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JMP  = 2'b10,
    PC_TRAP = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

  // Any non-zero low bits make a redirect target unusable for 32-bit fetch.
  function automatic logic is_misaligned(input logic [1:0] i_low);
    return i_low != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of the next fetch PC:
// trap > jump > branch > sequential > hold. Misaligned targets fall back to the trap vector.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_advance,
  input  logic            i_trap,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_branch_target,
  output logic [XLEN-1:0] o_next_pc_c,
  output pc_sel_e         o_sel_c,
  output logic            o_redirect_c,
  output logic            o_misalign_c
);

  always_comb begin
    o_next_pc_c  = i_pc;
    o_sel_c      = PC_SEQ;
    o_redirect_c = 1'b0;
    o_misalign_c = 1'b0;
    if (i_trap) begin
      o_next_pc_c  = TRAP_VEC;
      o_sel_c      = PC_TRAP;
      o_redirect_c = 1'b1;
    end else if (i_jump) begin
      o_redirect_c = 1'b1;
      if (is_misaligned(i_jump_target[1:0])) begin
        o_next_pc_c  = TRAP_VEC;
        o_sel_c      = PC_TRAP;
        o_misalign_c = 1'b1;
      end else begin
        o_next_pc_c = i_jump_target;
        o_sel_c     = PC_JMP;
      end
    end else if (i_branch) begin
      o_redirect_c = 1'b1;
      if (is_misaligned(i_branch_target[1:0])) begin
        o_next_pc_c  = TRAP_VEC;
        o_sel_c      = PC_TRAP;
        o_misalign_c = 1'b1;
      end else begin
        o_next_pc_c = i_branch_target;
        o_sel_c     = PC_BR;
      end
    end else if (i_advance) begin
      // Natural XLEN-bit wrap: the last word rolls over to address zero.
      o_next_pc_c = i_pc + XLEN'(INSN_BYTES);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, runs the BOOT/RUN/HALT FSM,
// presents the PC over valid/ready and counts accepted fetches.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_trap,
  input  logic            i_stall,
  input  logic            i_halt,
  input  logic            i_resume,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic [1:0]      o_pc_sel,
  output logic            o_flush,
  output logic            o_misalign,
  output logic [31:0]     o_fetch_cnt
);

  localparam int unsigned CNT_W = 32;

  pc_state_e        r_state;
  pc_state_e        w_next_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_pc_valid;
  pc_sel_e          r_pc_sel;
  logic             r_flush;
  logic             r_misalign;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic             w_advance;
  logic             w_trap_en;
  logic             w_jump_en;
  logic             w_branch_en;
  logic [XLEN-1:0]  w_next_pc;
  pc_sel_e          w_sel;
  logic             w_redirect;
  logic             w_misalign;

  // Redirects are ignored while booting; branches are also ignored while halted.
  assign w_advance   = r_pc_valid & i_if_ready & ~i_stall;
  assign w_trap_en   = i_trap & (r_state != ST_BOOT);
  assign w_jump_en   = i_jump & (r_state != ST_BOOT);
  assign w_branch_en = i_branch_taken & (r_state == ST_RUN);

  pc_next_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_pc_next_mux (
    .i_pc            (r_pc),
    .i_advance       (w_advance),
    .i_trap          (w_trap_en),
    .i_jump          (w_jump_en),
    .i_jump_target   (i_jump_target),
    .i_branch        (w_branch_en),
    .i_branch_target (i_branch_target),
    .o_next_pc_c     (w_next_pc),
    .o_sel_c         (w_sel),
    .o_redirect_c    (w_redirect),
    .o_misalign_c    (w_misalign)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT: w_next_state = ST_RUN;
      ST_RUN:  if (i_halt) w_next_state = ST_HALT;
      ST_HALT: if (i_resume | i_trap | i_jump) w_next_state = ST_RUN;
      default: w_next_state = ST_BOOT;
    endcase
  end

  // pc_valid is registered alongside the state so it tracks RUN exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_pc_valid  <= 1'b0;
      r_pc_sel    <= PC_SEQ;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_pc        <= w_next_pc;
      r_pc_valid  <= (w_next_state == ST_RUN);
      r_pc_sel    <= w_sel;
      r_flush     <= w_redirect;
      r_misalign  <= w_misalign;
      if (w_advance) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_valid  = r_pc_valid;
  assign o_pc_sel    = r_pc_sel;
  assign o_flush     = r_flush;
  assign o_misalign  = r_misalign;
  assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: a directed vector table covering the bring-up and corner
// sequences, then randomized traffic compared against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, branch_taken, jump, trap, stall, halt, resume, if_ready;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc;
  logic        pc_valid, flush, misalign;
  logic [1:0]  pc_sel;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: fetch mode is described by two flags.
  logic [31:0] m_pc, m_cnt;
  logic [1:0]  m_sel;
  bit          m_valid, m_flush, m_mis, m_booting, m_halted;

  typedef struct {
    logic        rst_n, trap, jump, br, stall, halt, resume, rdy;
    logic [31:0] jt, bt;
    logic [31:0] e_pc;
    logic        e_v;
    logic [1:0]  e_sel;
    logic        e_f, e_m;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_trap          (trap),
    .i_stall         (stall),
    .i_halt          (halt),
    .i_resume        (resume),
    .i_if_ready      (if_ready),
    .o_pc            (pc),
    .o_pc_valid      (pc_valid),
    .o_pc_sel        (pc_sel),
    .o_flush         (flush),
    .o_misalign      (misalign),
    .o_fetch_cnt     (fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Redirect target resolution: unaligned addresses go to the trap vector.
  task automatic resolve(input logic [31:0] tgt, input logic [1:0] sel_ok,
                         output logic [31:0] npc, output logic [1:0] nsel, output bit mis);
    if (tgt % 4 != 0) begin
      npc = TRAP_VEC; nsel = 2'b11; mis = 1'b1;
    end else begin
      npc = tgt; nsel = sel_ok; mis = 1'b0;
    end
  endtask

  // One clock edge of architectural behaviour, evaluated from the sampled inputs.
  task automatic model_step();
    bit running, accepted, tr, jp, br, mis;
    logic [31:0] npc;
    logic [1:0]  nsel;
    if (!rst_n) begin
      m_pc = RESET_PC; m_valid = 0; m_sel = 0; m_flush = 0; m_mis = 0;
      m_cnt = 0; m_booting = 1; m_halted = 0;
      return;
    end
    running  = !m_booting && !m_halted;
    accepted = m_valid && if_ready && !stall;
    tr = trap && !m_booting;
    jp = jump && !m_booting;
    br = branch_taken && running;
    npc = m_pc; nsel = 2'b00; mis = 0;
    if (tr) begin
      npc = TRAP_VEC; nsel = 2'b11;
    end else if (jp) begin
      resolve(jump_target, 2'b10, npc, nsel, mis);
    end else if (br) begin
      resolve(branch_target, 2'b01, npc, nsel, mis);
    end else if (accepted) begin
      npc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
    if (accepted) m_cnt = m_cnt + 1;
    m_flush = tr || jp || br;
    m_mis   = mis;
    m_pc    = npc;
    m_sel   = nsel;
    if (m_booting) m_booting = 0;
    else if (running) m_halted = halt;
    else if (resume || tr || jp) m_halted = 0;
    m_valid = !m_booting && !m_halted;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("model_pc", pc, m_pc);
    chk("model_valid", 32'(pc_valid), 32'(m_valid));
    chk("model_sel", 32'(pc_sel), 32'(m_sel));
    chk("model_flush", 32'(flush), 32'(m_flush));
    chk("model_misalign", 32'(misalign), 32'(m_mis));
    chk("model_cnt", fetch_cnt, m_cnt);
  endtask

  function automatic vec_t mk(input logic r, tr, jp, br, st, hl, rs, rdy,
                              input logic [31:0] jt, bt, epc, input logic ev,
                              input logic [1:0] esel, input logic ef, em,
                              input logic [31:0] ecnt);
    vec_t v;
    v.rst_n = r; v.trap = tr; v.jump = jp; v.br = br; v.stall = st; v.halt = hl;
    v.resume = rs; v.rdy = rdy; v.jt = jt; v.bt = bt; v.e_pc = epc; v.e_v = ev;
    v.e_sel = esel; v.e_f = ef; v.e_m = em; v.e_cnt = ecnt;
    return v;
  endfunction

  initial begin
    rst_n = 0; branch_taken = 0; jump = 0; trap = 0; stall = 0; halt = 0;
    resume = 0; if_ready = 1; branch_target = 0; jump_target = 0;

    //            rst tr jp br st hl rs rdy  jt            bt            pc            v sel f m cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h0,        1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h4,        1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h8,        1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'hC,        1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h10,       1, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h10,       1, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h10,       1, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h10,       1, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h14,       1, 0, 0, 0, 5));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 1, 32'h200,      32'h300, 32'h100,      1, 3, 1, 0, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h100,      1, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 32'h202,      32'h0,   32'h100,      1, 3, 1, 1, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h100,      1, 0, 0, 0, 5));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 32'h0,        32'h3C,  32'h3C,       1, 1, 1, 0, 6));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h40,       1, 0, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,   32'h40,       0, 0, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h40,       0, 0, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 32'h0,        32'h80,  32'h40,       0, 0, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,   32'h40,       1, 0, 0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h44,       1, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h500,      32'h0,   32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h0,        1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,  32'hFFFF_FFFC, 1, 2, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h0,        1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 32'h600,      32'h0,   32'h600,      0, 2, 1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h100,      1, 3, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h100,      1, 0, 0, 0, 2));

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; trap = vecs[i].trap; jump = vecs[i].jump;
      branch_taken = vecs[i].br; stall = vecs[i].stall; halt = vecs[i].halt;
      resume = vecs[i].resume; if_ready = vecs[i].rdy;
      jump_target = vecs[i].jt; branch_target = vecs[i].bt;
      step();
      chk($sformatf("row%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("row%0d_valid", i), 32'(pc_valid), 32'(vecs[i].e_v));
      chk($sformatf("row%0d_sel", i), 32'(pc_sel), 32'(vecs[i].e_sel));
      chk($sformatf("row%0d_flush", i), 32'(flush), 32'(vecs[i].e_f));
      chk($sformatf("row%0d_misalign", i), 32'(misalign), 32'(vecs[i].e_m));
      chk($sformatf("row%0d_cnt", i), fetch_cnt, vecs[i].e_cnt);
    end

    // Randomized traffic; jump targets sometimes land near the top of memory.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      trap         = ($urandom_range(0, 31) == 0);
      jump         = ($urandom_range(0, 15) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      halt         = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 7) == 0);
      if_ready     = ($urandom_range(0, 3) != 0);
      jump_target  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom() & 32'h1F))
                                                 : ($urandom() & 32'h0000_FFFF);
      branch_target = $urandom() & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) begin
        jump_target   = jump_target & 32'hFFFF_FFFC;
        branch_target = branch_target & 32'hFFFF_FFFC;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
